program_sender: RTL and testbench

Host-side counterpart of the on-board UART program loader. Streams an instruction section and a data section out through a `UartTx`-style byte interface. Each section is a 32-bit little-endian word count followed by the words themselves. After each section it waits for an acknowledge byte on a `UartRx`-style interface. Used in the loopback test bench and on a second FPGA acting as loader, with words fetched from a synchronous ROM.

---
 rtl/program_sender_pkg.sv | 25 ++
 rtl/program_sender_if.sv | 23 ++
 rtl/program_sender_ack_timer.sv | 26 ++
 rtl/program_sender.sv | 145 ++++++++++++++
 tb/tb_program_sender.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_sender_pkg.sv
// Types and constants shared between the host-side program sender and the
// board-side loader.
package loader_pkg;

    localparam logic [7:0] ACK_BYTE = 8'hAA;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_GUARD,
        ST_DRAIN,
        ST_ACK,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } section_t;

endpackage

// File: rtl/program_sender_if.sv
// ROM read port plus UART transmit/receive byte handshakes seen by the sender.
interface program_sender_if #(
    parameter int ADDR_W = 16
);
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              tx_start;
    logic [7:0]        sdata;
    logic              tx_busy;
    logic              rx_ready;
    logic [7:0]        rdata;

    modport master (
        output rd_sel, rd_addr, tx_start, sdata,
        input  rd_data, tx_busy, rx_ready, rdata
    );

    modport slave (
        input  rd_sel, rd_addr, tx_start, sdata,
        output rd_data, tx_busy, rx_ready, rdata
    );
endinterface

// File: rtl/program_sender_ack_timer.sv
// Loadable down-counter bounding the wait for an acknowledge byte.
module ack_timer #(
    parameter int W = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] count;

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);
endmodule

// File: rtl/program_sender.sv
// Streams an instruction section and a data section (count header + words,
// all little-endian) over a UART byte interface, waiting for an ack after each.
module program_sender
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 2**20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W:0]      n_instr,
    input  logic [ADDR_W:0]      n_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    program_sender_if.master     bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

    state_t          state;
    section_t        section;
    logic [ADDR_W:0] n_instr_q;
    logic [ADDR_W:0] n_data_q;
    logic [ADDR_W:0] word_idx;
    logic [1:0]      byte_idx;
    logic [31:0]     shift;

    logic [ADDR_W:0] cur_count;
    logic            words_left;
    logic            timer_load;
    logic            timer_expired;

    assign cur_count  = (section == INSTR) ? n_instr_q : n_data_q;
    assign words_left = (word_idx < cur_count);
    // Timer is armed on the same edge that moves DRAIN into ACK.
    assign timer_load = (state == ST_DRAIN) && !bus.tx_busy &&
                        (byte_idx == 2'd3) && !words_left;

    ack_timer #(.W(TW)) u_ack_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (TIMER_LOAD),
        .en         (state == ST_ACK),
        .expired    (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            section      <= INSTR;
            n_instr_q    <= '0;
            n_data_q     <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            shift        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            bus.tx_start <= 1'b0;
            bus.sdata    <= '0;
            bus.rd_sel   <= 1'b0;
            bus.rd_addr  <= '0;
        end else begin
            bus.tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_instr_q <= n_instr;
                        n_data_q  <= n_data;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        section   <= INSTR;
                        state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    shift    <= 32'(cur_count);
                    byte_idx <= '0;
                    word_idx <= '0;
                    state    <= ST_SEND;
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    shift    <= bus.rd_data;
                    word_idx <= word_idx + (ADDR_W+1)'(1);
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.sdata    <= shift[7:0];
                        shift        <= {8'h00, shift[31:8]};
                        state        <= ST_GUARD;
                    end
                end
                // The transmitter raises tx_busy one cycle late; skip that cycle.
                ST_GUARD: state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= ST_SEND;
                        end else if (words_left) begin
                            // Address is presented during FETCH so rd_data is ready in LOAD.
                            byte_idx    <= '0;
                            bus.rd_sel  <= section;
                            bus.rd_addr <= word_idx[ADDR_W-1:0];
                            state       <= ST_FETCH;
                        end else begin
                            state <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (bus.rx_ready) begin
                        if (bus.rdata == ACK_BYTE) begin
                            if (section == INSTR) begin
                                section <= DATA;
                                state   <= ST_HDR;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end
                        end else begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_ERR;
                        end
                    end else if (timer_expired) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: state <= ST_IDLE;
                default:         state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_sender.sv
// Scoreboard bench for program_sender: ROM and UART models, expected byte
// stream queued at stimulus time and compared against captured tx bytes.
module tb_program_sender;
    import loader_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 100;
    localparam int DEPTH   = 1 << ADDR_W;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [ADDR_W:0] n_instr = '0;
    logic [ADDR_W:0] n_data = '0;
    logic            busy;
    logic            done;
    logic            error;

    program_sender_if #(.ADDR_W(ADDR_W)) bus ();

    program_sender #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .n_instr (n_instr),
        .n_data  (n_data),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Synchronous ROMs with one cycle of read latency.
    logic [31:0] imem [DEPTH];
    logic [31:0] dmem [DEPTH];
    always @(posedge clock) bus.rd_data <= bus.rd_sel ? dmem[bus.rd_addr] : imem[bus.rd_addr];

    // Transmitter: busy for tx_cyc cycles starting the cycle after tx_start; ignores reset.
    int tx_cyc = 3;
    int tx_cnt = 0;
    always @(posedge clock) begin
        if (bus.tx_start === 1'b1) tx_cnt <= tx_cyc;
        else if (tx_cnt != 0)      tx_cnt <= tx_cnt - 1;
    end
    assign bus.tx_busy = (tx_cnt != 0);

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int   proto_err = 0;
    logic prev_tx = 1'b0;
    logic rom_moved = 1'b0;

    always @(negedge clock) begin
        if (bus.tx_start === 1'b1) begin
            got_q.push_back(bus.sdata);
            if (bus.tx_busy || prev_tx) proto_err++;
        end
        prev_tx = bus.tx_start;
        if (bus.rd_addr !== '0 || bus.rd_sel !== 1'b0) rom_moved = 1'b1;
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic new_test();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic start_xfer(input int ni, input int nd);
        @(negedge clock);
        n_instr = (ADDR_W+1)'(ni);
        n_data  = (ADDR_W+1)'(nd);
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (got_q.size() < n && k < 5000) begin
            @(negedge clock);
            k++;
        end
        if (got_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: %0d bytes sent, %0d required", tag, got_q.size(), n);
        end
    endtask

    // Returns on the first negedge with the transmitter idle after the last byte.
    task automatic wait_tx_idle();
        int k = 0;
        @(negedge clock);
        while (bus.tx_busy && k < 1000) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clock);
        bus.rx_ready = 1'b1;
        bus.rdata    = b;
        @(negedge clock);
        bus.rx_ready = 1'b0;
    endtask

    task automatic ack_section(input int n, input logic [7:0] b, input string tag);
        wait_bytes(n, tag);
        wait_tx_idle();
        send_rx(b);
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(done || error) && k < 2000) begin
            @(negedge clock);
            k++;
        end
        if (!(done || error)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: transfer did not finish, busy=%b", tag, busy);
        end
    endtask

    task automatic drain_scoreboard(input string tag);
        int idx = 0;
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_len: %0d bytes sent, %0d required", tag, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL %s_byte%0d: got %02h, required %02h", tag, idx, g, e);
            end
            idx++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        vectors++;
        if ({busy, done, error, bus.tx_start, bus.rd_sel} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy/done/error/tx_start/rd_sel=%b, required 00000",
                     {busy, done, error, bus.tx_start, bus.rd_sel});
        end
        vectors++;
        if (bus.sdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_sdata: got %02h, required 00", bus.sdata);
        end
        vectors++;
        if (bus.rd_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_rd_addr: got %0h, required 0", bus.rd_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        new_test();
        imem[0] = 32'h11223344;
        imem[1] = 32'hDEADBEEF;
        dmem[0] = 32'h00000005;
        push_word(32'd2); push_word(imem[0]); push_word(imem[1]);
        push_word(32'd1); push_word(dmem[0]);
        start_xfer(2, 1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy_rise: busy=%b, required 1", busy);
        end
        ack_section(12, ACK_BYTE, "basic_instr");
        ack_section(20, ACK_BYTE, "basic_data");
        wait_end("basic_end");
        vectors++;
        if ({done, error, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_flags: done/error/busy=%b, required 100", {done, error, busy});
        end
        drain_scoreboard("basic");
    endtask

    task automatic test_zero_counts();
        do_reset();
        new_test();
        rom_moved = 1'b0;
        repeat (8) exp_q.push_back(8'h00);
        start_xfer(0, 0);
        ack_section(4, ACK_BYTE, "zero_instr");
        ack_section(8, ACK_BYTE, "zero_data");
        wait_end("zero_end");
        vectors++;
        if (done !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_flags: done=%b error=%b, required 1 0", done, error);
        end
        vectors++;
        if (rom_moved !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_rom: ROM address moved, required no reads");
        end
        drain_scoreboard("zero");
    endtask

    task automatic test_bad_ack();
        new_test();
        imem[0] = 32'hCAFEF00D;
        dmem[0] = 32'h12345678;
        push_word(32'd1); push_word(imem[0]);
        start_xfer(1, 1);
        ack_section(8, 8'h55, "bad_instr");
        wait_end("bad_end");
        vectors++;
        if ({done, error, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL bad_flags: done/error/busy=%b, required 010", {done, error, busy});
        end
        repeat (40) @(negedge clock);
        drain_scoreboard("bad");
    endtask

    task automatic test_timeout();
        int k = 0;
        new_test();
        repeat (4) exp_q.push_back(8'h00);
        start_xfer(0, 2);
        wait_bytes(4, "tmo_hdr");
        wait_tx_idle();
        // ACK is entered on the next posedge; error must appear TIMEOUT cycles after it.
        while (!error && k < 3 * TIMEOUT) begin
            @(negedge clock);
            k++;
        end
        vectors++;
        if (k != TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL tmo_latency: error after %0d negedges, required %0d", k, TIMEOUT + 1);
        end
        vectors++;
        if ({done, error, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL tmo_flags: done/error/busy=%b, required 010", {done, error, busy});
        end
        drain_scoreboard("tmo");
    endtask

    task automatic test_ack_at_expiry();
        new_test();
        dmem[0] = 32'h00000077;
        repeat (4) exp_q.push_back(8'h00);
        push_word(32'd1); push_word(dmem[0]);
        start_xfer(0, 1);
        wait_bytes(4, "edge_hdr");
        wait_tx_idle();
        repeat (TIMEOUT - 1) @(negedge clock);
        send_rx(ACK_BYTE);
        vectors++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL edge_ack_wins: error=%b busy=%b, required 0 1", error, busy);
        end
        ack_section(12, ACK_BYTE, "edge_data");
        wait_end("edge_end");
        vectors++;
        if (done !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_flags: done=%b error=%b, required 1 0", done, error);
        end
        drain_scoreboard("edge");
    endtask

    task automatic test_slow_tx();
        new_test();
        tx_cyc  = 20;
        imem[0] = 32'h0A0B0C0D;
        dmem[0] = 32'h01020304;
        push_word(32'd1); push_word(imem[0]);
        push_word(32'd1); push_word(dmem[0]);
        start_xfer(1, 1);
        wait_bytes(2, "slow_mid");
        send_rx(8'h55);
        ack_section(8, ACK_BYTE, "slow_instr");
        ack_section(16, ACK_BYTE, "slow_data");
        wait_end("slow_end");
        vectors++;
        if (done !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL slow_flags: done=%b error=%b, required 1 0", done, error);
        end
        drain_scoreboard("slow");
        tx_cyc = 3;
    endtask

    task automatic test_full_count();
        new_test();
        tx_cyc = 1;
        for (int i = 0; i < DEPTH; i++) imem[i] = $urandom();
        push_word(32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) push_word(imem[i]);
        push_word(32'd0);
        start_xfer(DEPTH, 0);
        ack_section(4 + 4 * DEPTH, ACK_BYTE, "full_instr");
        ack_section(8 + 4 * DEPTH, ACK_BYTE, "full_data");
        wait_end("full_end");
        vectors++;
        if (done !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL full_flags: done=%b error=%b, required 1 0", done, error);
        end
        drain_scoreboard("full");
        tx_cyc = 3;
    endtask

    task automatic test_reset_mid();
        new_test();
        tx_cyc  = 5;
        imem[0] = 32'h89ABCDEF;
        imem[1] = 32'h76543210;
        dmem[0] = 32'h0BADF00D;
        start_xfer(2, 1);
        wait_bytes(6, "rst_mid");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if ({busy, done, error, bus.tx_start, bus.rd_sel} !== 5'b0 ||
            bus.sdata !== 8'h00 || bus.rd_addr !== '0) begin
            miscompares++;
            $display("FAIL rst_outputs: busy/done/error/tx_start/rd_sel=%b sdata=%02h rd_addr=%0h, required all 0",
                     {busy, done, error, bus.tx_start, bus.rd_sel}, bus.sdata, bus.rd_addr);
        end
        reset = 1'b0;
        new_test();
        push_word(32'd2); push_word(imem[0]); push_word(imem[1]);
        push_word(32'd1); push_word(dmem[0]);
        start_xfer(2, 1);
        ack_section(12, ACK_BYTE, "rst_instr");
        ack_section(20, ACK_BYTE, "rst_data");
        wait_end("rst_end");
        vectors++;
        if (done !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flags: done=%b error=%b, required 1 0", done, error);
        end
        drain_scoreboard("rst");
        tx_cyc = 3;
    endtask

    task automatic test_protocol();
        vectors++;
        if (proto_err != 0) begin
            miscompares++;
            $display("FAIL tx_protocol: %0d tx_start pulses while busy or back-to-back, required 0", proto_err);
        end
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        bus.rdata    = 8'h00;
        test_reset();
        test_basic();
        test_zero_counts();
        test_bad_ack();
        test_timeout();
        test_ack_at_expiry();
        test_slow_tx();
        test_full_count();
        test_reset_mid();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
